register_file: RTL and testbench
================================

Name: register_file

Overview:
- Architectural register file with rename tags. It sits directly downstream of the reorder buffer.
- The ROB forwards the decoder's rs1/rs2 lookups to this block and receives back either the committed value or the ROB tag of the in-flight producer.
- The ROB allocates rd renames at dispatch and writes retired results at commit.
- A ROB-issued flush (misprediction/JALR) discards all pending renames.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired to zero)
DATA_W, 32, register data width
ROB_W, 4, ROB tag width (16-entry ROB)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global stall; state frozen when low
rob2reg_rs1_request  input  5  source-1 register index
rob2reg_rs2_request  input  5  source-2 register index
reg2rob_rs1_value  output  DATA_W  source-1 value (committed or bypassed)
reg2rob_rs2_value  output  DATA_W  source-2 value
reg2rob_rs1_rename  output  ROB_W  source-1 producer tag (0 when not renamed)
reg2rob_rs2_rename  output  ROB_W  source-2 producer tag
reg2rob_rs1_if_rename  output  1  source-1 still pending in ROB
reg2rob_rs2_if_rename  output  1  source-2 still pending in ROB
rob2reg_rename_enable  input  1  dispatch allocates rd this cycle
rob2reg_rd_request  input  5  destination register being renamed
rob2reg_rename_reorder  input  ROB_W  ROB tag assigned to rd
rob2reg_commit_enable  input  1  ROB retires an entry this cycle
rob2reg_commit_des  input  5  retiring destination register
rob2reg_commit_value  input  DATA_W  retiring value
rob2reg_commit_reorder  input  ROB_W  retiring entry tag
rob_rst_enable  input  1  flush: clear all rename state

Behaviour:
- State per register: value[DATA_W], busy[1], tag[ROB_W].
- Reset (rst_in low, async): all values 0, all busy 0, all tags 0. Read outputs are combinational from state, so after reset they read value 0, rename 0, if_rename 0.
- Reads are combinational, zero latency. For each source s:
  - s==0: value 0, rename 0, if_rename 0.
  - Commit bypass: commit_enable && commit_des==s && busy[s] && tag[s]==commit_reorder gives value=commit_value, if_rename 0, rename 0.
  - Else busy[s]: if_rename 1, rename=tag[s], value=value[s] (don't-care to consumer).
  - Else: value[s], rename 0, if_rename 0.
- Reads never see a same-cycle rename. An instruction's own rd allocation must not alias its sources.
- Writes occur on posedge clk_in and only when rdy_in is high; rdy_in low freezes all state.
- Commit, when commit_des!=0:
  - value[des] <= commit_value, unconditionally.
  - busy[des] cleared only if tag[des]==commit_reorder, because a younger rename keeps the register busy.
- Rename, when rename_enable && rd!=0 && !rob_rst_enable: busy[rd] <= 1, tag[rd] <= rename_reorder.
- Same cycle commit and rename on the same register: the value is written, and the rename wins, so busy=1 with the new tag.
- Flush (rob_rst_enable) clears all busy bits and zeros all tags. A same-cycle commit still writes its value; a same-cycle rename is ignored.
- Writes targeting x0 are dropped; value[0] stays 0.
- Reset asserted mid-operation overrides everything immediately.
- Deassertion is sampled at the next clock edge; the first post-reset edge may already rename or commit.

Decomposition:
- Shared def package holds: DATA_WIDTH, REG_WIDTH (5), ROB_WIDTH (4), ZERO_DATA, ZERO_ROB, TRUE/FALSE.
- One sub-module, reg_read_port, instantiated twice. It implements the per-source zero/bypass/busy mux so the rs1 and rs2 paths are identical by construction.

Test Plan:
- Reset then read x5 -> value 0, if_rename 0, rename 0. Assert rst_in low mid-run -> all outputs 0 immediately, with no clock edge.
- Rename x5 to tag 3, next cycle read x5 -> if_rename 1, rename 3. Commit x5=0xDEADBEEF tag 3 -> same-cycle read returns 0xDEADBEEF, if_rename 0; next cycle busy clear.
- Rename x7 tag 2, then rename x7 tag 9, then commit x7 tag 2 value 0x11 -> value 0x11 stored, x7 still busy with tag 9, read shows if_rename 1, rename 9.
- Same cycle commit x4 tag 1 (value 0x22) and rename x4 tag 6 -> next cycle x4 busy, tag 6, stored value 0x22.
- Rename x1..x3, assert rob_rst_enable with rename x8 tag 5 -> all if_rename 0, x8 not busy. Write x0 via commit 0xFF -> x0 reads 0.
- rdy_in low with commit x9 = 0x33 -> x9 unchanged. rdy_in high for the same commit -> x9 = 0x33.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared definitions for the renaming architectural register file.
// Widths here are the defaults for the top-level parameters.
package register_file_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_WIDTH  = 5;
  localparam int ROB_WIDTH  = 4;

  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/register_file_read_port.sv
// One source-operand lookup: x0 forcing, same-cycle commit bypass, and
// in-flight producer tag reporting. Instantiated once per source.
module reg_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int ROB_W  = ROB_WIDTH,
  parameter int IDX_W  = REG_WIDTH
) (
  input  logic [IDX_W-1:0]  src_idx_i,
  input  logic [DATA_W-1:0] entry_value_i,
  input  logic              entry_busy_i,
  input  logic [ROB_W-1:0]  entry_tag_i,
  input  logic              commit_enable_i,
  input  logic [IDX_W-1:0]  commit_des_i,
  input  logic [DATA_W-1:0] commit_value_i,
  input  logic [ROB_W-1:0]  commit_reorder_i,
  output logic [DATA_W-1:0] value_o,
  output logic [ROB_W-1:0]  rename_o,
  output logic              if_rename_o
);

  logic bypassHit;

  // The bypass only applies when the retiring entry is the register's current producer.
  assign bypassHit = commit_enable_i && (commit_des_i == src_idx_i) &&
                     entry_busy_i && (entry_tag_i == commit_reorder_i);

  always_comb begin
    value_o     = '0;
    rename_o    = '0;
    if_rename_o = FALSE;
    if (src_idx_i == '0) begin
      value_o     = '0;
    end else if (bypassHit) begin
      value_o     = commit_value_i;
    end else if (entry_busy_i) begin
      value_o     = entry_value_i;
      rename_o    = entry_tag_i;
      if_rename_o = TRUE;
    end else begin
      value_o     = entry_value_i;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags, fed by the ROB:
// dispatch renames, commit writes back, flush drops every pending rename.
module register_file
  import register_file_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = DATA_WIDTH,
  parameter int ROB_W   = ROB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [REG_WIDTH-1:0] rob2reg_rs1_request,
  input  logic [REG_WIDTH-1:0] rob2reg_rs2_request,
  output logic [DATA_W-1:0]    reg2rob_rs1_value,
  output logic [DATA_W-1:0]    reg2rob_rs2_value,
  output logic [ROB_W-1:0]     reg2rob_rs1_rename,
  output logic [ROB_W-1:0]     reg2rob_rs2_rename,
  output logic                 reg2rob_rs1_if_rename,
  output logic                 reg2rob_rs2_if_rename,
  input  logic                 rob2reg_rename_enable,
  input  logic [REG_WIDTH-1:0] rob2reg_rd_request,
  input  logic [ROB_W-1:0]     rob2reg_rename_reorder,
  input  logic                 rob2reg_commit_enable,
  input  logic [REG_WIDTH-1:0] rob2reg_commit_des,
  input  logic [DATA_W-1:0]    rob2reg_commit_value,
  input  logic [ROB_W-1:0]     rob2reg_commit_reorder,
  input  logic                 rob_rst_enable
);

  logic [DATA_W-1:0]  value_q [REG_NUM];
  logic [DATA_W-1:0]  value_d [REG_NUM];
  logic [ROB_W-1:0]   tag_q   [REG_NUM];
  logic [ROB_W-1:0]   tag_d   [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  logic commitValid;
  logic renameValid;

  assign commitValid = rob2reg_commit_enable && (rob2reg_commit_des != '0);
  assign renameValid = rob2reg_rename_enable && (rob2reg_rd_request != '0) && !rob_rst_enable;

  // Rename is applied after commit so a same-register rename keeps the register busy.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (commitValid) begin
      value_d[rob2reg_commit_des] = rob2reg_commit_value;
      if (tag_q[rob2reg_commit_des] == rob2reg_commit_reorder) begin
        busy_d[rob2reg_commit_des] = FALSE;
      end
    end
    if (rob_rst_enable) begin
      busy_d = '0;
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = ZERO_ROB;
      end
    end else if (renameValid) begin
      busy_d[rob2reg_rd_request] = TRUE;
      tag_d[rob2reg_rd_request]  = rob2reg_rename_reorder;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      busy_q  <= busy_d;
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  reg_read_port #(
    .DATA_W (DATA_W),
    .ROB_W  (ROB_W),
    .IDX_W  (REG_WIDTH)
  ) u_rs1_port (
    .src_idx_i        (rob2reg_rs1_request),
    .entry_value_i    (value_q[rob2reg_rs1_request]),
    .entry_busy_i     (busy_q[rob2reg_rs1_request]),
    .entry_tag_i      (tag_q[rob2reg_rs1_request]),
    .commit_enable_i  (rob2reg_commit_enable),
    .commit_des_i     (rob2reg_commit_des),
    .commit_value_i   (rob2reg_commit_value),
    .commit_reorder_i (rob2reg_commit_reorder),
    .value_o          (reg2rob_rs1_value),
    .rename_o         (reg2rob_rs1_rename),
    .if_rename_o      (reg2rob_rs1_if_rename)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ROB_W  (ROB_W),
    .IDX_W  (REG_WIDTH)
  ) u_rs2_port (
    .src_idx_i        (rob2reg_rs2_request),
    .entry_value_i    (value_q[rob2reg_rs2_request]),
    .entry_busy_i     (busy_q[rob2reg_rs2_request]),
    .entry_tag_i      (tag_q[rob2reg_rs2_request]),
    .commit_enable_i  (rob2reg_commit_enable),
    .commit_des_i     (rob2reg_commit_des),
    .commit_value_i   (rob2reg_commit_value),
    .commit_reorder_i (rob2reg_commit_reorder),
    .value_o          (reg2rob_rs2_value),
    .rename_o         (reg2rob_rs2_rename),
    .if_rename_o      (reg2rob_rs2_if_rename)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed scenarios for register_file with hand-computed expectations.
module tb_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [4:0]  rob2reg_rs1_request;
  logic [4:0]  rob2reg_rs2_request;
  logic [31:0] reg2rob_rs1_value;
  logic [31:0] reg2rob_rs2_value;
  logic [3:0]  reg2rob_rs1_rename;
  logic [3:0]  reg2rob_rs2_rename;
  logic        reg2rob_rs1_if_rename;
  logic        reg2rob_rs2_if_rename;
  logic        rob2reg_rename_enable;
  logic [4:0]  rob2reg_rd_request;
  logic [3:0]  rob2reg_rename_reorder;
  logic        rob2reg_commit_enable;
  logic [4:0]  rob2reg_commit_des;
  logic [31:0] rob2reg_commit_value;
  logic [3:0]  rob2reg_commit_reorder;
  logic        rob_rst_enable;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  register_file dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    .rob2reg_rs1_request    (rob2reg_rs1_request),
    .rob2reg_rs2_request    (rob2reg_rs2_request),
    .reg2rob_rs1_value      (reg2rob_rs1_value),
    .reg2rob_rs2_value      (reg2rob_rs2_value),
    .reg2rob_rs1_rename     (reg2rob_rs1_rename),
    .reg2rob_rs2_rename     (reg2rob_rs2_rename),
    .reg2rob_rs1_if_rename  (reg2rob_rs1_if_rename),
    .reg2rob_rs2_if_rename  (reg2rob_rs2_if_rename),
    .rob2reg_rename_enable  (rob2reg_rename_enable),
    .rob2reg_rd_request     (rob2reg_rd_request),
    .rob2reg_rename_reorder (rob2reg_rename_reorder),
    .rob2reg_commit_enable  (rob2reg_commit_enable),
    .rob2reg_commit_des     (rob2reg_commit_des),
    .rob2reg_commit_value   (rob2reg_commit_value),
    .rob2reg_commit_reorder (rob2reg_commit_reorder),
    .rob_rst_enable         (rob_rst_enable)
  );

  // Advance one active edge and leave inputs stable 1 time unit later.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idleInputs();
    rob2reg_rename_enable  = 1'b0;
    rob2reg_rd_request     = 5'd0;
    rob2reg_rename_reorder = 4'd0;
    rob2reg_commit_enable  = 1'b0;
    rob2reg_commit_des     = 5'd0;
    rob2reg_commit_value   = 32'd0;
    rob2reg_commit_reorder = 4'd0;
    rob_rst_enable         = 1'b0;
  endtask

  task automatic doRename(input logic [4:0] rd, input logic [3:0] tag);
    rob2reg_rename_enable  = 1'b1;
    rob2reg_rd_request     = rd;
    rob2reg_rename_reorder = tag;
    tick();
    rob2reg_rename_enable  = 1'b0;
  endtask

  task automatic test_reset();
    rob2reg_rs1_request = 5'd5;
    rob2reg_rs2_request = 5'd5;
    #1;
    vectors++;
    if (reg2rob_rs1_value !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_value got %h want %h", reg2rob_rs1_value, 32'd0);
    end
    vectors++;
    if (reg2rob_rs1_if_rename !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_if_rename got %b want 0", reg2rob_rs1_if_rename);
    end
    vectors++;
    if (reg2rob_rs2_rename !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_rename got %h want 0", reg2rob_rs2_rename);
    end
  endtask

  task automatic test_rename_commit();
    doRename(5'd5, 4'd3);
    rob2reg_rs1_request = 5'd5;
    rob2reg_rs2_request = 5'd5;
    #1;
    vectors++;
    if (reg2rob_rs1_if_rename !== 1'b1 || reg2rob_rs1_rename !== 4'd3) begin
      miscompares++;
      $display("[TB] FAIL rename_x5 got if=%b tag=%h want if=1 tag=3",
               reg2rob_rs1_if_rename, reg2rob_rs1_rename);
    end
    rob2reg_commit_enable  = 1'b1;
    rob2reg_commit_des     = 5'd5;
    rob2reg_commit_value   = 32'hDEADBEEF;
    rob2reg_commit_reorder = 4'd3;
    #1;
    vectors++;
    if (reg2rob_rs1_value !== 32'hDEADBEEF || reg2rob_rs1_if_rename !== 1'b0
        || reg2rob_rs1_rename !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL bypass_rs1 got v=%h if=%b tag=%h want v=deadbeef if=0 tag=0",
               reg2rob_rs1_value, reg2rob_rs1_if_rename, reg2rob_rs1_rename);
    end
    vectors++;
    if (reg2rob_rs2_value !== 32'hDEADBEEF || reg2rob_rs2_if_rename !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bypass_rs2 got v=%h if=%b want v=deadbeef if=0",
               reg2rob_rs2_value, reg2rob_rs2_if_rename);
    end
    tick();
    rob2reg_commit_enable = 1'b0;
    #1;
    vectors++;
    if (reg2rob_rs1_value !== 32'hDEADBEEF || reg2rob_rs1_if_rename !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL commit_x5 got v=%h if=%b want v=deadbeef if=0",
               reg2rob_rs1_value, reg2rob_rs1_if_rename);
    end
  endtask

  task automatic test_younger_rename();
    doRename(5'd7, 4'd2);
    doRename(5'd7, 4'd9);
    rob2reg_rs1_request    = 5'd7;
    rob2reg_commit_enable  = 1'b1;
    rob2reg_commit_des     = 5'd7;
    rob2reg_commit_value   = 32'h11;
    rob2reg_commit_reorder = 4'd2;
    #1;
    vectors++;
    if (reg2rob_rs1_if_rename !== 1'b1 || reg2rob_rs1_rename !== 4'd9) begin
      miscompares++;
      $display("[TB] FAIL stale_no_bypass got if=%b tag=%h want if=1 tag=9",
               reg2rob_rs1_if_rename, reg2rob_rs1_rename);
    end
    tick();
    rob2reg_commit_enable = 1'b0;
    #1;
    vectors++;
    if (reg2rob_rs1_if_rename !== 1'b1 || reg2rob_rs1_rename !== 4'd9
        || reg2rob_rs1_value !== 32'h11) begin
      miscompares++;
      $display("[TB] FAIL younger_keeps_busy got if=%b tag=%h v=%h want if=1 tag=9 v=11",
               reg2rob_rs1_if_rename, reg2rob_rs1_rename, reg2rob_rs1_value);
    end
  endtask

  task automatic test_same_cycle();
    rob2reg_commit_enable  = 1'b1;
    rob2reg_commit_des     = 5'd4;
    rob2reg_commit_value   = 32'h22;
    rob2reg_commit_reorder = 4'd1;
    rob2reg_rename_enable  = 1'b1;
    rob2reg_rd_request     = 5'd4;
    rob2reg_rename_reorder = 4'd6;
    tick();
    idleInputs();
    rob2reg_rs2_request = 5'd4;
    #1;
    vectors++;
    if (reg2rob_rs2_if_rename !== 1'b1 || reg2rob_rs2_rename !== 4'd6
        || reg2rob_rs2_value !== 32'h22) begin
      miscompares++;
      $display("[TB] FAIL same_cycle_x4 got if=%b tag=%h v=%h want if=1 tag=6 v=22",
               reg2rob_rs2_if_rename, reg2rob_rs2_rename, reg2rob_rs2_value);
    end
  endtask

  task automatic test_flush_x0();
    doRename(5'd1, 4'd10);
    doRename(5'd2, 4'd11);
    doRename(5'd3, 4'd12);
    rob2reg_rs1_request = 5'd2;
    #1;
    vectors++;
    if (reg2rob_rs1_if_rename !== 1'b1 || reg2rob_rs1_rename !== 4'd11) begin
      miscompares++;
      $display("[TB] FAIL pre_flush_x2 got if=%b tag=%h want if=1 tag=b",
               reg2rob_rs1_if_rename, reg2rob_rs1_rename);
    end
    rob_rst_enable         = 1'b1;
    rob2reg_rename_enable  = 1'b1;
    rob2reg_rd_request     = 5'd8;
    rob2reg_rename_reorder = 4'd5;
    tick();
    idleInputs();
    for (int r = 1; r <= 8; r++) begin
      rob2reg_rs1_request = r[4:0];
      #1;
      vectors++;
      if (reg2rob_rs1_if_rename !== 1'b0 || reg2rob_rs1_rename !== 4'd0) begin
        miscompares++;
        $display("[TB] FAIL flush_x%0d got if=%b tag=%h want if=0 tag=0",
                 r, reg2rob_rs1_if_rename, reg2rob_rs1_rename);
      end
    end
    rob2reg_rs1_request = 5'd7;
    #1;
    vectors++;
    if (reg2rob_rs1_value !== 32'h11) begin
      miscompares++;
      $display("[TB] FAIL flush_keeps_value got %h want 00000011", reg2rob_rs1_value);
    end
    rob2reg_rs2_request    = 5'd0;
    rob2reg_commit_enable  = 1'b1;
    rob2reg_commit_des     = 5'd0;
    rob2reg_commit_value   = 32'hFF;
    rob2reg_commit_reorder = 4'd0;
    #1;
    vectors++;
    if (reg2rob_rs2_value !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL x0_bypass got %h want 0", reg2rob_rs2_value);
    end
    tick();
    idleInputs();
    #1;
    vectors++;
    if (reg2rob_rs2_value !== 32'd0 || reg2rob_rs2_if_rename !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL x0_write got v=%h if=%b want v=0 if=0",
               reg2rob_rs2_value, reg2rob_rs2_if_rename);
    end
  endtask

  task automatic test_stall();
    rdy_in                 = 1'b0;
    rob2reg_commit_enable  = 1'b1;
    rob2reg_commit_des     = 5'd9;
    rob2reg_commit_value   = 32'h33;
    rob2reg_commit_reorder = 4'd0;
    rob2reg_rename_enable  = 1'b1;
    rob2reg_rd_request     = 5'd10;
    rob2reg_rename_reorder = 4'd7;
    tick();
    rob2reg_rename_enable = 1'b0;
    rob2reg_rs1_request   = 5'd9;
    rob2reg_rs2_request   = 5'd10;
    #1;
    vectors++;
    if (reg2rob_rs1_value !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL stall_commit got %h want 0", reg2rob_rs1_value);
    end
    vectors++;
    if (reg2rob_rs2_if_rename !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_rename got if=%b want 0", reg2rob_rs2_if_rename);
    end
    rdy_in = 1'b1;
    tick();
    idleInputs();
    #1;
    vectors++;
    if (reg2rob_rs1_value !== 32'h33) begin
      miscompares++;
      $display("[TB] FAIL unstall_commit got %h want 00000033", reg2rob_rs1_value);
    end
  endtask

  task automatic test_async_reset();
    doRename(5'd12, 4'd8);
    rob2reg_rs1_request = 5'd9;
    rob2reg_rs2_request = 5'd12;
    #1;
    vectors++;
    if (reg2rob_rs2_if_rename !== 1'b1 || reg2rob_rs2_rename !== 4'd8) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_x12 got if=%b tag=%h want if=1 tag=8",
               reg2rob_rs2_if_rename, reg2rob_rs2_rename);
    end
    rst_in = 1'b0;
    #1;
    vectors++;
    if (reg2rob_rs1_value !== 32'd0 || reg2rob_rs2_if_rename !== 1'b0
        || reg2rob_rs2_rename !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got v=%h if=%b tag=%h want all 0",
               reg2rob_rs1_value, reg2rob_rs2_if_rename, reg2rob_rs2_rename);
    end
    #2;
    rst_in = 1'b1;
    rob2reg_rename_enable  = 1'b1;
    rob2reg_rd_request     = 5'd5;
    rob2reg_rename_reorder = 4'd4;
    tick();
    idleInputs();
    rob2reg_rs1_request = 5'd5;
    #1;
    vectors++;
    if (reg2rob_rs1_if_rename !== 1'b1 || reg2rob_rs1_rename !== 4'd4
        || reg2rob_rs1_value !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL first_edge_rename got if=%b tag=%h v=%h want if=1 tag=4 v=0",
               reg2rob_rs1_if_rename, reg2rob_rs1_rename, reg2rob_rs1_value);
    end
  endtask

  initial begin
    rst_in              = 1'b0;
    rdy_in              = 1'b1;
    rob2reg_rs1_request = 5'd0;
    rob2reg_rs2_request = 5'd0;
    idleInputs();
    #12;
    test_reset();
    rst_in = 1'b1;
    tick();
    test_rename_commit();
    test_younger_rename();
    test_same_cycle();
    test_flush_x0();
    test_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
